// File: rtl/vxe_pipe_sink_if.sv
`default_nettype none
// ============================================================================
//  Module      : vxe_pipe_sink_if
//  Description : Interface bundle for vxe_pipe_sink. It carries the producer
//                issue handshake, the companion pipe output, the consumer
//                valid/ready handshake, the credit count and the error flag.
//  Revision    : 1.0  initial release
// ============================================================================
interface vxe_pipe_sink_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    logic                    i_vld;
    logic                    i_rdy;
    logic [DATA_WIDTH-1:0]   p_data;
    logic                    o_vld;
    logic [DATA_WIDTH-1:0]   o_data;
    logic                    o_rdy;
    logic [$clog2(DEPTH):0]  credits;
    logic                    err;

    // Producer/consumer side (drives issue, pipe data and consumer ready)
    modport master (
        output i_vld, p_data, o_rdy,
        input  i_rdy, o_vld, o_data, credits, err
    );

    // Sink side
    modport slave (
        input  i_vld, p_data, o_rdy,
        output i_rdy, o_vld, o_data, credits, err
    );
endinterface
`default_nettype wire

// File: rtl/vxe_pipe_sink.sv
`default_nettype none
// ============================================================================
//  Module      : vxe_pipe_sink
//  Description : Credit-based receive end for a free-running fixed-latency
//                vxe_pipe. A valid shift register follows each issued word
//                through the pipe; emerging words are captured into a
//                DEPTH-entry FIFO. Credits cover FIFO space plus in-flight
//                words, so a stalled consumer never loses data.
//  Option      : VXE_PIPE_SINK_CHECK_EN builds the sticky protocol checker
//                driving err; otherwise err is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module vxe_pipe_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1,
    parameter int DEPTH      = 4
) (
    input  wire logic       clk,
    input  wire logic       nrst,
    vxe_pipe_sink_if.slave  bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic                    w_rdy;
    logic                    w_issue;
    logic                    w_pop;
    logic                    w_write;
    logic                    w_vld;

    logic [LATENCY-1:0]      vsr_q, vsr_d;
    logic [c_PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]      occ_q, occ_d;
    logic [c_CNT_W-1:0]      credits_q, credits_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    assign w_rdy   = (credits_q != '0);
    assign w_issue = bus.i_vld && w_rdy;
    assign w_vld   = (occ_q != '0);
    assign w_pop   = w_vld && bus.o_rdy;
    // The oldest in-flight slot is aligned with the pipe output
    assign w_write = vsr_q[0];

    // New issues enter at the top of the valid shift register and walk down
    generate
        if (LATENCY == 1) begin : g_vsr_single
            assign vsr_d = w_issue;
        end else begin : g_vsr_multi
            assign vsr_d = {w_issue, vsr_q[LATENCY-1:1]};
        end
    endgenerate

    // Pointer, occupancy and credit bookkeeping
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        credits_d = credits_q;
        if (w_write) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        case ({w_write, w_pop})
            2'b10:   occ_d = occ_q + c_CNT_W'(1);
            2'b01:   occ_d = occ_q - c_CNT_W'(1);
            default: occ_d = occ_q;
        endcase
        case ({w_issue, w_pop})
            2'b10:   credits_d = credits_q - c_CNT_W'(1);
            2'b01:   credits_d = credits_q + c_CNT_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    // Control state; reset discards every buffered and in-flight word
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vsr_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            credits_q <= c_DEPTH;
        end else begin
            vsr_q     <= vsr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            credits_q <= credits_d;
        end
    end

    // Storage is deliberately not reset; validity is tracked by occupancy
    always_ff @(posedge clk) begin
        if (w_write) begin
            mem_q[wr_ptr_q] <= bus.p_data;
        end
    end

    assign bus.i_rdy   = w_rdy;
    assign bus.o_vld   = w_vld;
    assign bus.o_data  = mem_q[rd_ptr_q];
    assign bus.credits = credits_q;

`ifdef VXE_PIPE_SINK_CHECK_EN
    logic err_q;
    logic w_err_set;

    // Issue without credit, plus defensive counter over/underflow detection
    assign w_err_set = (bus.i_vld && !w_rdy)
                     || (w_write && !w_pop && (occ_q == c_DEPTH))
                     || (w_pop && (occ_q == '0))
                     || (w_pop && !w_issue && (credits_q == c_DEPTH))
                     || (w_issue && (credits_q == '0));

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_q <= 1'b0;
        end else if (w_err_set) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vxe_pipe_sink.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_vxe_pipe_sink
//  Description : Directed self-checking bench for vxe_pipe_sink. Instance A
//                (LATENCY=3, DEPTH=4) covers single word, stall fill, issue
//                and pop at one credit, pointer wrap and mid-stream reset.
//                Instance B (LATENCY=3, DEPTH=8) covers streaming.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vxe_pipe_sink;
    localparam int DW  = 32;
    localparam int LAT = 3;
    localparam int DA  = 4;
    localparam int DB  = 8;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    vxe_pipe_sink_if #(.DATA_WIDTH(DW), .DEPTH(DA)) ifa ();
    vxe_pipe_sink_if #(.DATA_WIDTH(DW), .DEPTH(DB)) ifb ();

    vxe_pipe_sink #(.DATA_WIDTH(DW), .LATENCY(LAT), .DEPTH(DA)) u_dut_a (
        .clk  (clk),
        .nrst (nrst),
        .bus  (ifa)
    );

    vxe_pipe_sink #(.DATA_WIDTH(DW), .LATENCY(LAT), .DEPTH(DB)) u_dut_b (
        .clk  (clk),
        .nrst (nrst),
        .bus  (ifb)
    );

    // Free-running companion pipes
    logic [DW-1:0] din_a, din_b;
    logic [DW-1:0] pipe_a [LAT];
    logic [DW-1:0] pipe_b [LAT];

    always @(posedge clk) begin
        pipe_a[0] <= din_a;
        pipe_b[0] <= din_b;
        for (int s = 1; s < LAT; s++) begin
            pipe_a[s] <= pipe_a[s-1];
            pipe_b[s] <= pipe_b[s-1];
        end
    end

    assign ifa.p_data = pipe_a[LAT-1];
    assign ifb.p_data = pipe_b[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard for A: credits follow accepted-minus-popped words, order kept
    task automatic sb_a();
        check("a_credit_model", 64'(ifa.credits), 64'(DA - qa.size()));
        check("a_irdy_model", 64'(ifa.i_rdy), 64'((DA - qa.size()) != 0));
        if (ifa.o_vld && ifa.o_rdy) begin
            if (qa.size() == 0) begin
                check("a_unexpected_out", 64'(ifa.o_vld), 64'(0));
            end else begin
                check("a_order", 64'(ifa.o_data), 64'(qa[0]));
                void'(qa.pop_front());
            end
        end
        if (ifa.i_vld && ifa.i_rdy) qa.push_back(din_a);
    endtask

    // Scoreboard for B
    task automatic sb_b();
        check("b_credit_model", 64'(ifb.credits), 64'(DB - qb.size()));
        if (ifb.o_vld && ifb.o_rdy) begin
            if (qb.size() == 0) begin
                check("b_unexpected_out", 64'(ifb.o_vld), 64'(0));
            end else begin
                check("b_order", 64'(ifb.o_data), 64'(qb[0]));
                void'(qb.pop_front());
            end
        end
        if (ifb.i_vld && ifb.i_rdy) qb.push_back(din_b);
    endtask

    // One cycle: scoreboard at the falling edge, return 1ns after rising edge
    task automatic tick();
        @(negedge clk);
        if (mon_en) begin
            sb_a();
            sb_b();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifa.i_vld = 1'b0; ifa.o_rdy = 1'b0; din_a = '0;
        ifb.i_vld = 1'b0; ifb.o_rdy = 1'b0; din_b = '0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        idle_inputs();
        #2 nrst = 1'b0;
        @(posedge clk);
        #4 nrst = 1'b1;
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    int n_acc;

    initial begin
        idle_inputs();
        #1 nrst = 1'b0;
        @(posedge clk);
        #1;
        // Reset state
        check("rst_credits_a", 64'(ifa.credits), 64'(4));
        check("rst_credits_b", 64'(ifb.credits), 64'(8));
        check("rst_irdy", 64'(ifa.i_rdy), 64'(1));
        check("rst_ovld", 64'(ifa.o_vld), 64'(0));
        check("rst_err", 64'(ifa.err), 64'(0));
        @(posedge clk);
        #4 nrst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Single word 0xA5 issued at cycle 0
        for (int k = 0; k < 6; k++) begin
            ifa.o_rdy = 1'b1;
            ifa.i_vld = (k == 0);
            din_a     = (k == 0) ? 32'hA5 : 32'h0;
            check("t1_credits", 64'(ifa.credits), 64'((k >= 1 && k <= 4) ? 3 : 4));
            check("t1_ovld", 64'(ifa.o_vld), 64'(k == 4));
            if (k == 4) check("t1_odata", 64'(ifa.o_data), 64'h A5);
            tick();
        end

        // Stall fill: 8 offered words, only 4 credits
        n_acc = 0;
        for (int k = 0; k < 8; k++) begin
            ifa.o_rdy = 1'b0;
            ifa.i_vld = 1'b1;
            din_a     = 32'(k + 1);
            check("t2_irdy", 64'(ifa.i_rdy), 64'(k < 4));
`ifdef VXE_PIPE_SINK_CHECK_EN
            check("t2_err", 64'(ifa.err), 64'(k >= 5));
`else
            check("t2_err", 64'(ifa.err), 64'(0));
`endif
            if (ifa.i_rdy) n_acc++;
            tick();
        end
        ifa.i_vld = 1'b0;
        check("t2_accepted", 64'(n_acc), 64'(4));
        check("t2_full_credits", 64'(ifa.credits), 64'(0));
        check("t2_full_ovld", 64'(ifa.o_vld), 64'(1));
        for (int k = 0; k < 4; k++) begin
            ifa.o_rdy = 1'b1;
            check("t2_drain_vld", 64'(ifa.o_vld), 64'(1));
            check("t2_drain_data", 64'(ifa.o_data), 64'(k + 1));
            tick();
        end
        check("t2_empty", 64'(ifa.o_vld), 64'(0));
        check("t2_credits_back", 64'(ifa.credits), 64'(4));
`ifdef VXE_PIPE_SINK_CHECK_EN
        check("t2_err_held", 64'(ifa.err), 64'(1));
`else
        check("t2_err_held", 64'(ifa.err), 64'(0));
`endif

        do_reset();
        check("t2_err_cleared", 64'(ifa.err), 64'(0));

        // Bring credits to 1 with three buffered words
        for (int k = 0; k < 3; k++) begin
            ifa.o_rdy = 1'b0;
            ifa.i_vld = 1'b1;
            din_a     = 32'(16 + k);
            tick();
        end
        ifa.i_vld = 1'b0;
        repeat (3) tick();
        check("t4_credits_one", 64'(ifa.credits), 64'(1));
        check("t4_buffered_vld", 64'(ifa.o_vld), 64'(1));
        // Issue and pop together; runs several FIFO laps
        for (int k = 0; k < 20; k++) begin
            ifa.o_rdy = 1'b1;
            ifa.i_vld = 1'b1;
            din_a     = 32'(256 + k);
            if (k < 3) begin
                check("t4_credits_hold", 64'(ifa.credits), 64'(1));
                check("t4_irdy_hold", 64'(ifa.i_rdy), 64'(1));
            end
            tick();
        end
        ifa.i_vld = 1'b0;
        repeat (10) tick();
        check("t4_all_popped", 64'(qa.size()), 64'(0));
        check("t4_credits_back", 64'(ifa.credits), 64'(4));
        check("t4_empty", 64'(ifa.o_vld), 64'(0));

        // Mid-stream reset with 2 buffered and 2 in flight
        for (int k = 0; k < 4; k++) begin
            ifa.o_rdy = 1'b0;
            ifa.i_vld = 1'b1;
            din_a     = 32'(80 + k);
            tick();
        end
        ifa.i_vld = 1'b0;
        tick();
        check("t5_pre_vld", 64'(ifa.o_vld), 64'(1));
        check("t5_pre_credits", 64'(ifa.credits), 64'(0));
        mon_en = 1'b0;
        #2 nrst = 1'b0;
        #1;
        check("t5_async_ovld", 64'(ifa.o_vld), 64'(0));
        check("t5_async_credits", 64'(ifa.credits), 64'(4));
        check("t5_async_irdy", 64'(ifa.i_rdy), 64'(1));
        @(posedge clk);
        #4 nrst = 1'b1;
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ifa.o_rdy = 1'b1;
            check("t5_no_stale", 64'(ifa.o_vld), 64'(0));
            check("t5_err_clear", 64'(ifa.err), 64'(0));
            tick();
        end
        check("t5_credits", 64'(ifa.credits), 64'(4));

        // Streaming on B: 100 back-to-back words, first output at cycle 4
        for (int k = 0; k < 110; k++) begin
            ifb.o_rdy = 1'b1;
            ifb.i_vld = (k < 100);
            din_b     = 32'(1000 + k);
            if (k < 100) check("t3_irdy", 64'(ifb.i_rdy), 64'(1));
            if (k >= 4 && k < 104) begin
                check("t3_ovld", 64'(ifb.o_vld), 64'(1));
                check("t3_odata", 64'(ifb.o_data), 64'(1000 + k - 4));
            end else begin
                check("t3_ovld_idle", 64'(ifb.o_vld), 64'(0));
            end
            tick();
        end
        check("t3_credits", 64'(ifb.credits), 64'(8));
        check("t3_err", 64'(ifb.err), 64'(0));
        check("t3_all_popped", 64'(qb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
